// File: rtl/move_sequencer_if.sv
// -----------------------------------------------------------------------------
// move_sequencer_if
// Groups the move-loading bus, the run/clear controls, the executor handshake
// and the status flags of move_sequencer.
//
// Signals:
//   load_move[3:0], load_valid, load_ready : move append bus
//   clear, run                             : buffer clear / start execution
//   next_move[3:0], move_start, move_done  : stepper move executor handshake
//   busy, seq_done, moves_executed[7:0]    : run status
//   bad_move, fault                        : sticky error flags
//   dbg_state[2:0]                         : current sequencer FSM state
//   reverse                                : traversal direction, only when
//                                            MOVE_SEQ_INVERSE_EN is defined
//
// Modports:
//   slave  : the sequencer itself
//   master : the environment (upstream loader, executor, controller)
// -----------------------------------------------------------------------------
interface move_sequencer_if;
  logic [3:0] load_move;
  logic       load_valid;
  logic       load_ready;
  logic       clear;
  logic       run;
  logic [3:0] next_move;
  logic       move_start;
  logic       move_done;
  logic       busy;
  logic       seq_done;
  logic [7:0] moves_executed;
  logic       bad_move;
  logic       fault;
  logic [2:0] dbg_state;
`ifdef MOVE_SEQ_INVERSE_EN
  logic       reverse;
`endif

  modport slave (
    input  load_move, load_valid, clear, run, move_done,
`ifdef MOVE_SEQ_INVERSE_EN
    input  reverse,
`endif
    output load_ready, next_move, move_start, busy, seq_done,
    output moves_executed, bad_move, fault, dbg_state
  );

  modport master (
    output load_move, load_valid, clear, run, move_done,
`ifdef MOVE_SEQ_INVERSE_EN
    output reverse,
`endif
    input  load_ready, next_move, move_start, busy, seq_done,
    input  moves_executed, bad_move, fault, dbg_state
  );
endinterface

// File: rtl/move_sequencer.sv
// -----------------------------------------------------------------------------
// move_sequencer
// Buffers a list of 4-bit cube move codes and issues them one at a time to the
// stepper move executor. Each move: latch code on next_move, pulse move_start,
// ignore move_done for BLANK_CYCLES, wait for move_done (with timeout), then
// idle SETTLE_CYCLES before fetching the next code.
//
// Move codes: 2..13 valid (bits [3:1] face R,U,F,L,B,D; bit 0 inverse),
// 15 terminates the sequence, 0/1/14 are skipped and flag bad_move.
//
// Ports:
//   clock  : system clock
//   reset  : synchronous, active-high
//   sif    : move_sequencer_if.slave (load bus, controls, executor handshake,
//            status, debug state)
//
// Load handshake: a move is appended on every clock edge where load_valid and
// load_ready are both high; load_ready is high only in IDLE with free space,
// and load_valid without load_ready is simply dropped.
//
// Optional feature macro: MOVE_SEQ_INVERSE_EN adds sif.reverse, sampled with
// run; when set the buffer is replayed from the last entry down to entry 0
// with bit 0 of every issued code flipped, undoing the stored sequence.
// -----------------------------------------------------------------------------
module move_sequencer #(
  parameter int DEPTH          = 64,
  parameter int BLANK_CYCLES   = 4,
  parameter int SETTLE_CYCLES  = 1000,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input logic             clock,
  input logic             reset,
  move_sequencer_if.slave sif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam int T_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES)
    ? ((TIMEOUT_CYCLES > BLANK_CYCLES) ? TIMEOUT_CYCLES : BLANK_CYCLES)
    : ((SETTLE_CYCLES > BLANK_CYCLES) ? SETTLE_CYCLES : BLANK_CYCLES);
  localparam int TW = $clog2(T_MAX + 1);

  // Timer reload values: the counter runs down to zero, so N cycles in a
  // state need a reload of N-1 (zero-length settings degrade to one cycle).
  localparam int BLANK_M1   = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
  localparam int SETTLE_M1  = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
  localparam int TIMEOUT_M1 = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  localparam logic [TW-1:0] BLANK_LD   = TW'(BLANK_M1);
  localparam logic [TW-1:0] SETTLE_LD  = TW'(SETTLE_M1);
  localparam logic [TW-1:0] TIMEOUT_LD = TW'(TIMEOUT_M1);
  localparam logic [TW-1:0] T_ONE      = TW'(1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE      = CW'(1);
  localparam logic [3:0]    CODE_NULL  = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_ISSUE     = 3'd2,
    S_BLANK     = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_SETTLE    = 3'd5,
    S_FINISH    = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [3:0]      next_move_q, next_move_d;
  logic [7:0]      exec_q, exec_d;
  logic            bad_q, bad_d;
  logic            fault_q, fault_d;
  logic            move_start_q;
  logic            busy_q;
  logic            seq_done_q;
  logic            load_ready_q;
  logic [3:0]      mem_q [DEPTH];

  logic            wr_en;
  logic [CW-1:0]   rd_idx;
  logic [3:0]      rd_code;
  logic            code_ok;
  logic [3:0]      issue_code;

`ifdef MOVE_SEQ_INVERSE_EN
  logic            rev_q, rev_d;
`endif

  // load_ready_q already encodes "IDLE and not full".
  assign wr_en = sif.load_valid && load_ready_q;

`ifdef MOVE_SEQ_INVERSE_EN
  // Reverse replay walks cnt-1 .. 0 using the same forward idx.
  assign rd_idx     = rev_q ? (cnt_q - C_ONE - idx_q) : idx_q;
  assign issue_code = rd_code ^ {3'b000, rev_q};
`else
  assign rd_idx     = idx_q;
  assign issue_code = rd_code;
`endif

  assign rd_code = mem_q[rd_idx[AW-1:0]];
  assign code_ok = (rd_code >= 4'd2) && (rd_code <= 4'd13);

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[cnt_q[AW-1:0]] <= sif.load_move;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    next_move_d = next_move_q;
    exec_d      = exec_q;
    bad_d       = bad_q;
    fault_d     = fault_q;
`ifdef MOVE_SEQ_INVERSE_EN
    rev_d       = rev_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (sif.clear) begin
          // clear takes priority over run in the same cycle
          cnt_d   = '0;
          bad_d   = 1'b0;
          fault_d = 1'b0;
        end else begin
          if (wr_en) begin
            cnt_d = cnt_q + C_ONE;
          end
          if (sif.run) begin
            idx_d   = '0;
            exec_d  = '0;
`ifdef MOVE_SEQ_INVERSE_EN
            rev_d   = sif.reverse;
`endif
            state_d = (cnt_q == '0) ? S_FINISH : S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (idx_q == cnt_q || rd_code == CODE_NULL) begin
          state_d = S_FINISH;
        end else if (!code_ok) begin
          bad_d = 1'b1;
          idx_d = idx_q + C_ONE;
        end else begin
          next_move_d = issue_code;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (exec_q != 8'hFF) begin
          exec_d = exec_q + 8'd1;
        end
        state_d = S_BLANK;
      end
      S_BLANK: begin
        if (tmr_q == '0) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (sif.move_done) begin
          state_d = S_SETTLE;
        end else if (tmr_q == '0) begin
          fault_d = 1'b1;
          state_d = S_FINISH;
        end
      end
      S_SETTLE: begin
        if (tmr_q == '0) begin
          idx_d   = idx_q + C_ONE;
          state_d = S_FETCH;
        end
      end
      S_FINISH: begin
        next_move_d = CODE_NULL;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // One shared down-counter, reloaded whenever the state changes.
  always_comb begin
    tmr_d = tmr_q;
    if (state_d != state_q) begin
      case (state_d)
        S_BLANK:     tmr_d = BLANK_LD;
        S_WAIT_DONE: tmr_d = TIMEOUT_LD;
        S_SETTLE:    tmr_d = SETTLE_LD;
        default:     tmr_d = '0;
      endcase
    end else if (tmr_q != '0) begin
      tmr_d = tmr_q - T_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      tmr_q        <= '0;
      next_move_q  <= CODE_NULL;
      exec_q       <= '0;
      bad_q        <= 1'b0;
      fault_q      <= 1'b0;
      move_start_q <= 1'b0;
      busy_q       <= 1'b0;
      seq_done_q   <= 1'b0;
      load_ready_q <= 1'b1;
`ifdef MOVE_SEQ_INVERSE_EN
      rev_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      tmr_q        <= tmr_d;
      next_move_q  <= next_move_d;
      exec_q       <= exec_d;
      bad_q        <= bad_d;
      fault_q      <= fault_d;
      // Status flags are registered from the next state so they line up
      // with the state they describe.
      move_start_q <= (state_d == S_ISSUE);
      busy_q       <= (state_d != S_IDLE);
      seq_done_q   <= (state_d == S_FINISH);
      load_ready_q <= (state_d == S_IDLE) && (cnt_d < DEPTH_C);
`ifdef MOVE_SEQ_INVERSE_EN
      rev_q        <= rev_d;
`endif
    end
  end

  assign sif.load_ready     = load_ready_q;
  assign sif.next_move      = next_move_q;
  assign sif.move_start     = move_start_q;
  assign sif.busy           = busy_q;
  assign sif.seq_done       = seq_done_q;
  assign sif.moves_executed = exec_q;
  assign sif.bad_move       = bad_q;
  assign sif.fault          = fault_q;
  assign sif.dbg_state      = state_q;

endmodule

// File: tb/tb_move_sequencer.sv
// -----------------------------------------------------------------------------
// tb_move_sequencer
// Directed and randomized checks of move_sequencer with a small executor model
// and a list-level reference of which codes a run should issue.
// -----------------------------------------------------------------------------
module tb_move_sequencer;
  localparam int DEPTH   = 8;
  localparam int BLANK   = 4;
  localparam int SETTLE  = 10;
  localparam int TIMEOUT = 100;

  logic clock = 1'b0;
  logic reset = 1'b1;

  move_sequencer_if sif();

  move_sequencer #(
    .DEPTH(DEPTH), .BLANK_CYCLES(BLANK),
    .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .sif(sif)
  );

  // clock / reset
  always #5 clock = ~clock;

  int         total = 0;
  int         bad   = 0;
  logic [3:0] buf_model[$];
  logic [3:0] exp_q[$];
  logic [3:0] obs_q[$];
  logic       exp_bad;
  int         sd_count   = 0;
  int         exec_delay = 20;
  bit         exec_hang  = 0;
  int         ex_cnt     = 0;

  // executor model: goes busy on move_start, idle exec_delay cycles later
  always @(negedge clock) begin
    if (sif.move_start === 1'b1) begin
      ex_cnt = exec_delay;
      sif.move_done = 1'b0;
    end else if (ex_cnt > 0) begin
      ex_cnt--;
    end else if (!exec_hang) begin
      sif.move_done = 1'b1;
    end
  end

  // monitor
  always @(negedge clock) begin
    if (!reset) begin
      if (sif.move_start === 1'b1) obs_q.push_back(sif.next_move);
      if (sif.seq_done === 1'b1) sd_count++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear();
    sif.clear = 1'b1;
    tick();
    sif.clear = 1'b0;
    buf_model.delete();
  endtask

  task automatic load_code(input logic [3:0] c);
    sif.load_move  = c;
    sif.load_valid = 1'b1;
    tick();
    sif.load_valid = 1'b0;
    if (buf_model.size() < DEPTH) buf_model.push_back(c);
  endtask

  // reference: which codes a run issues and whether any were skipped
  task automatic model(input bit rev);
    int n;
    logic [3:0] c;
    n = buf_model.size();
    exp_q.delete();
    exp_bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      c = rev ? buf_model[n-1-i] : buf_model[i];
      if (c == 4'd15) break;
      if (c < 4'd2 || c == 4'd14) exp_bad = 1'b1;
      else exp_q.push_back(rev ? (c ^ 4'd1) : c);
    end
  endtask

  task automatic run_and_check(input string tag, input bit rev, input bit timed);
    int start_sd;
    int budget;
    int n;
    model(rev);
    obs_q.delete();
    start_sd = sd_count;
    sif.run = 1'b1;
`ifdef MOVE_SEQ_INVERSE_EN
    sif.reverse = rev;
`endif
    tick();
    sif.run = 1'b0;
    if (timed) begin
      check({tag, "_busy"}, sif.busy, 1);
      check({tag, "_start_n1"}, sif.move_start, 0);
      tick();
      check({tag, "_start_n2"}, sif.move_start, 1);
      check({tag, "_first_code"}, sif.next_move, exp_q[0]);
      tick();
      check({tag, "_start_drop"}, sif.move_start, 0);
    end
    budget = (buf_model.size() + 2) * (BLANK + SETTLE + exec_delay + 10) + 50;
    while (sd_count == start_sd && budget > 0) begin
      tick();
      budget--;
    end
    check({tag, "_seq_done_seen"}, (sd_count != start_sd), 1);
    tick();
    tick();
    check({tag, "_seq_done_once"}, sd_count - start_sd, 1);
    check({tag, "_n_issued"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_code"}, obs_q[i], exp_q[i]);
    check({tag, "_executed"}, sif.moves_executed, (exp_q.size() > 255) ? 255 : exp_q.size());
    check({tag, "_bad_move"}, sif.bad_move, exp_bad);
    check({tag, "_next_move_null"}, sif.next_move, 4'd15);
    check({tag, "_idle"}, sif.busy, 0);
    check({tag, "_fault"}, sif.fault, 0);
  endtask

  task automatic empty_run(input string tag);
    int start_sd;
    obs_q.delete();
    start_sd = sd_count;
    sif.run = 1'b1;
    tick();
    sif.run = 1'b0;
    check({tag, "_seq_done"}, sif.seq_done, 1);
    check({tag, "_no_start"}, sif.move_start, 0);
    tick();
    check({tag, "_seq_done_drop"}, sif.seq_done, 0);
    check({tag, "_idle"}, sif.busy, 0);
    check({tag, "_no_moves"}, obs_q.size(), 0);
    check({tag, "_executed"}, sif.moves_executed, 0);
  endtask

  initial begin
    int len;
    int r;
    int start_sd;
    bit rev;
    sif.load_move  = 4'd0;
    sif.load_valid = 1'b0;
    sif.clear      = 1'b0;
    sif.run        = 1'b0;
`ifdef MOVE_SEQ_INVERSE_EN
    sif.reverse    = 1'b0;
`endif
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // reset values
    check("rst_next_move", sif.next_move, 4'd15);
    check("rst_move_start", sif.move_start, 0);
    check("rst_busy", sif.busy, 0);
    check("rst_seq_done", sif.seq_done, 0);
    check("rst_executed", sif.moves_executed, 0);
    check("rst_bad_move", sif.bad_move, 0);
    check("rst_fault", sif.fault, 0);
    check("rst_load_ready", sif.load_ready, 1);

    // basic sequence with exact issue timing
    exec_delay = 20;
    load_code(4'd4); load_code(4'd7); load_code(4'd2);
    run_and_check("basic", 1'b0, 1'b1);
    run_and_check("replay", 1'b0, 1'b0);

    // terminator stops the run
    do_clear();
    load_code(4'd2); load_code(4'd15); load_code(4'd8);
    run_and_check("null_term", 1'b0, 1'b0);

    // invalid codes skipped, bad_move sticky until clear
    do_clear();
    load_code(4'd0); load_code(4'd14); load_code(4'd6);
    run_and_check("invalid", 1'b0, 1'b0);
    repeat (3) tick();
    check("bad_sticky", sif.bad_move, 1);
    do_clear();
    check("bad_cleared", sif.bad_move, 0);

    // timeout with the executor never reporting done
    exec_hang = 1'b1;
    load_code(4'd5);
    sif.run = 1'b1;
    tick();
    sif.run = 1'b0;
    tick();
    check("to_start", sif.move_start, 1);
    repeat (104) tick();
    check("to_fault_early", sif.fault, 0);
    tick();
    check("to_fault", sif.fault, 1);
    check("to_seq_done", sif.seq_done, 1);
    tick();
    check("to_idle", sif.busy, 0);
    check("to_executed", sif.moves_executed, 1);
    exec_hang = 1'b0;
    repeat (5) tick();
    check("to_fault_sticky", sif.fault, 1);
    do_clear();
    check("to_fault_cleared", sif.fault, 0);

    // fill to capacity, extra load dropped
    for (int i = 0; i < DEPTH; i++) load_code(4'($urandom_range(2, 13)));
    check("full_load_ready", sif.load_ready, 0);
    load_code(4'd9);
    check("full_cnt_model", buf_model.size(), DEPTH);
    exec_delay = 3;
    run_and_check("full", 1'b0, 1'b0);

    // clear and run together: clear wins
    start_sd = sd_count;
    sif.clear = 1'b1;
    sif.run   = 1'b1;
    tick();
    sif.clear = 1'b0;
    sif.run   = 1'b0;
    buf_model.delete();
    tick();
    check("clr_run_idle", sif.busy, 0);
    check("clr_run_no_done", sd_count - start_sd, 0);
    check("clr_load_ready", sif.load_ready, 1);
    empty_run("empty");

    // reset mid-run
    exec_delay = 20;
    load_code(4'd5); load_code(4'd6); load_code(4'd7);
    sif.run = 1'b1;
    tick();
    sif.run = 1'b0;
    repeat (12) tick();
    start_sd = sd_count;
    reset = 1'b1;
    tick();
    check("mid_rst_start", sif.move_start, 0);
    check("mid_rst_next_move", sif.next_move, 4'd15);
    check("mid_rst_busy", sif.busy, 0);
    check("mid_rst_load_ready", sif.load_ready, 1);
    reset = 1'b0;
    buf_model.delete();
    tick();
    check("mid_rst_no_done", sd_count - start_sd, 0);
    empty_run("post_rst");

    // randomized sequences
    for (int it = 0; it < 8; it++) begin
      do_clear();
      exec_delay = $urandom_range(0, 30);
      len = $urandom_range(1, DEPTH);
      for (int k = 0; k < len; k++) begin
        r = $urandom_range(0, 9);
        if (r < 7) load_code(4'($urandom_range(2, 13)));
        else if (r < 9) load_code((r == 7) ? 4'($urandom_range(0, 1)) : 4'd14);
        else load_code(4'd15);
      end
      rev = 1'b0;
`ifdef MOVE_SEQ_INVERSE_EN
      rev = 1'($urandom_range(0, 1));
`endif
      run_and_check("rand", rev, 1'b0);
    end

`ifdef MOVE_SEQ_INVERSE_EN
    // reverse replay undoes the stored sequence
    do_clear();
    exec_delay = 20;
    load_code(4'd4); load_code(4'd7); load_code(4'd2);
    run_and_check("reverse", 1'b1, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
